// File: rtl/k005297_page_deframer_if.sv
// Bubble-memory page deframer bus: arm/abort control, serial bit input and byte/page status outputs.
interface k005297_page_deframer_if;
  logic       i_ARM;
  logic       i_ABORT;
  logic       i_BITSTRB;
  logic       i_BIT;
  logic [7:0] o_BYTE;
  logic       o_BYTE_VLD;
  logic       o_PAGE_DONE;
  logic       o_CRC_ERR;
  logic       o_BUSY;

  modport master (
    output i_ARM, i_ABORT, i_BITSTRB, i_BIT,
    input  o_BYTE, o_BYTE_VLD, o_PAGE_DONE, o_CRC_ERR, o_BUSY
  );

  modport slave (
    input  i_ARM, i_ABORT, i_BITSTRB, i_BIT,
    output o_BYTE, o_BYTE_VLD, o_PAGE_DONE, o_CRC_ERR, o_BUSY
  );
endinterface

// File: rtl/k005297_page_deframer.sv
// Sync-word hunter and page deserializer for the bubble-memory read stream.
// Optional K005297_DEFRAMER_CRC_EN adds the 2-byte CRC-16-CCITT tail check.
module k005297_page_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int unsigned PAGE_BYTES = 64
) (
  input logic                      i_CLK,
  input logic                      i_MRST_n,
  input logic                      i_CEN_n,
  k005297_page_deframer_if.slave   bus
);

  localparam int unsigned HUNT_CW  = 5;
  localparam logic [HUNT_CW-1:0] HUNT_SAT = HUNT_CW'(16);
  localparam logic [7:0] LAST_BYTE = 8'(PAGE_BYTES - 1);

`ifdef K005297_DEFRAMER_CRC_EN
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_HUNT = 3'd1, S_DATA = 3'd2,
                            S_CRC = 3'd3, S_DONE = 3'd4} state_t;
`else
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_HUNT = 3'd1, S_DATA = 3'd2,
                            S_DONE = 3'd4} state_t;
`endif

  state_t               state_q, state_nxt;
  logic [15:0]          sr_q;
  logic [HUNT_CW-1:0]   hunt_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           byte_cnt_q;
  logic [7:0]           byte_q;
  logic                 vld_q;
  logic                 done_q;
  logic                 busy_q;

  logic                 en_c;
  logic [15:0]          sr_shift_c;
  logic                 byte_end_c;
  logic                 lock_c;
  logic                 busy_nxt_c;

  assign en_c       = ~i_CEN_n;
  assign sr_shift_c = {sr_q[14:0], bus.i_BIT};
  assign byte_end_c = bus.i_BITSTRB && (bit_cnt_q == 3'd7);
  // A lock needs 16 real bits since arming; the cleared register alone never counts.
  assign lock_c     = bus.i_BITSTRB && (hunt_cnt_q >= HUNT_CW'(15)) && (sr_shift_c == SYNC_WORD);

`ifdef K005297_DEFRAMER_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_nxt_c;
  logic        crc_err_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_nxt_c     = crc_byte(crc_q, sr_shift_c[7:0]);
  assign bus.o_CRC_ERR = crc_err_q;
`else
  logic done_pend_q;
  assign bus.o_CRC_ERR = 1'b0;
`endif

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.i_ARM) state_nxt = S_HUNT;
      S_HUNT:  if (lock_c) state_nxt = S_DATA;
`ifdef K005297_DEFRAMER_CRC_EN
      S_DATA:  if (byte_end_c && byte_cnt_q == LAST_BYTE) state_nxt = S_CRC;
      S_CRC:   if (byte_end_c && byte_cnt_q == 8'd1) state_nxt = S_DONE;
`else
      S_DATA:  if (byte_end_c && byte_cnt_q == LAST_BYTE) state_nxt = S_DONE;
`endif
      S_DONE:  if (bus.i_ARM) state_nxt = S_HUNT;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.i_ABORT) state_nxt = S_IDLE;
    busy_nxt_c = (state_nxt == S_HUNT) || (state_nxt == S_DATA)
`ifdef K005297_DEFRAMER_CRC_EN
                 || (state_nxt == S_CRC)
`endif
                 ;
  end

  always_ff @(posedge i_CLK or negedge i_MRST_n) begin
    if (!i_MRST_n)  state_q <= S_IDLE;
    else if (en_c)  state_q <= state_nxt;
  end

  // Datapath: shift register, counters, CRC and registered outputs.
  always_ff @(posedge i_CLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sr_q        <= '0;
      hunt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      byte_q      <= '0;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef K005297_DEFRAMER_CRC_EN
      crc_q       <= 16'hFFFF;
      crc_err_q   <= 1'b0;
`else
      done_pend_q <= 1'b0;
`endif
    end else if (en_c) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= busy_nxt_c;
`ifndef K005297_DEFRAMER_CRC_EN
      done_q      <= done_pend_q & ~bus.i_ABORT;
      done_pend_q <= 1'b0;
`endif
      if (bus.i_ABORT) begin
        hunt_cnt_q <= '0;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.i_ARM) begin
              sr_q       <= '0;
              hunt_cnt_q <= '0;
`ifdef K005297_DEFRAMER_CRC_EN
              crc_err_q  <= 1'b0;
`endif
            end
          end
          S_HUNT: begin
            if (bus.i_BITSTRB) begin
              sr_q <= sr_shift_c;
              if (hunt_cnt_q != HUNT_SAT) hunt_cnt_q <= hunt_cnt_q + HUNT_CW'(1);
              if (lock_c) begin
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
`ifdef K005297_DEFRAMER_CRC_EN
                crc_q      <= 16'hFFFF;
`endif
              end
            end
          end
          S_DATA: begin
            if (bus.i_BITSTRB) begin
              sr_q      <= sr_shift_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_end_c) begin
                byte_q <= sr_shift_c[7:0];
                vld_q  <= 1'b1;
`ifdef K005297_DEFRAMER_CRC_EN
                crc_q  <= crc_nxt_c;
`endif
                if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_q <= '0;
`ifndef K005297_DEFRAMER_CRC_EN
                  done_pend_q <= 1'b1;
`endif
                end else begin
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                end
              end
            end
          end
`ifdef K005297_DEFRAMER_CRC_EN
          S_CRC: begin
            if (bus.i_BITSTRB) begin
              sr_q      <= sr_shift_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_end_c) begin
                crc_q <= crc_nxt_c;
                if (byte_cnt_q == 8'd1) begin
                  byte_cnt_q <= '0;
                  done_q     <= 1'b1;
                  crc_err_q  <= (crc_nxt_c != 16'h0000);
                end else begin
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                end
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.o_BYTE      = byte_q;
  assign bus.o_BYTE_VLD  = vld_q;
  assign bus.o_PAGE_DONE = done_q;
  assign bus.o_BUSY      = busy_q;

endmodule

// File: tb/tb_k005297_page_deframer.sv
// Scoreboard bench for k005297_page_deframer: directed pages with queued expected bytes/done events.
module tb_k005297_page_deframer;
  localparam int unsigned PB = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic cen_n;
  always #5 clk = ~clk;

  k005297_page_deframer_if bus();

  k005297_page_deframer #(.SYNC_WORD(16'hA5C3), .PAGE_BYTES(PB)) dut (
    .i_CLK    (clk),
    .i_MRST_n (rst_n),
    .i_CEN_n  (cen_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_byte_q[$];
  logic       exp_done_q[$];
  logic [7:0] msg [PB] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

`ifdef K005297_DEFRAMER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each pulse is consumed at the negedge before the enabled edge that ends it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cen_n === 1'b0) begin
      if (bus.o_BYTE_VLD === 1'b1) begin
        if (exp_byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte_vld: got byte %h expected no pulse", bus.o_BYTE);
        end else check("byte", 16'(bus.o_BYTE), 16'(exp_byte_q.pop_front()));
      end
      if (bus.o_PAGE_DONE === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_page_done: got pulse expected none");
        end else check("crc_err_at_done", 16'(bus.o_CRC_ERR), 16'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    bus.i_BITSTRB = 1'b1; bus.i_BIT = b;
    tick();
    bus.i_BITSTRB = 1'b0; bus.i_BIT = 1'b0;
  endtask

  task automatic gap_bit(input logic b);
    bus.i_BITSTRB = 1'b0; bus.i_BIT = ~b;
    tick();
    send_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic arm();
    bus.i_ARM = 1'b1;
    tick();
    bus.i_ARM = 1'b0;
  endtask

  task automatic send_noise();
    logic [4:0] n;
    n = 5'b10110;
    for (int i = 4; i >= 0; i--) send_bit(n[i]);
  endtask

  // Sync, nine data bytes, then the two CRC bytes 29 and crc_lo.
  task automatic send_body(input logic [7:0] crc_lo, input logic exp_err, input logic gappy);
    logic [15:0] s;
    s = 16'hA5C3;
    exp_done_q.push_back(CRC_ON ? exp_err : 1'b0);
    for (int i = 15; i >= 0; i--) begin
      if (gappy && (i % 3 == 0)) gap_bit(s[i]);
      else send_bit(s[i]);
    end
    for (int k = 0; k < int'(PB); k++) begin
      exp_byte_q.push_back(msg[k]);
      for (int i = 7; i >= 0; i--) begin
        if (gappy && k == 2 && i == 3) begin
          cen_n = 1'b1; bus.i_BITSTRB = 1'b1; bus.i_BIT = ~msg[k][i];
          repeat (3) tick();
          cen_n = 1'b0; bus.i_BITSTRB = 1'b0;
        end
        send_bit(msg[k][i]);
      end
    end
    send_byte(8'h29);
    send_byte(crc_lo);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"},  16'(bus.o_BYTE), 16'h0);
    check({tag, "_vld"},   16'(bus.o_BYTE_VLD), 16'h0);
    check({tag, "_done"},  16'(bus.o_PAGE_DONE), 16'h0);
    check({tag, "_err"},   16'(bus.o_CRC_ERR), 16'h0);
    check({tag, "_busy"},  16'(bus.o_BUSY), 16'h0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_bytes_left"}, 16'(exp_byte_q.size()), 16'h0);
    check({tag, "_done_left"},  16'(exp_done_q.size()), 16'h0);
  endtask

  initial begin
    logic [15:0] s;
    s = 16'hA5C3;
    rst_n = 1'b0; cen_n = 1'b0;
    bus.i_ARM = 1'b0; bus.i_ABORT = 1'b0; bus.i_BITSTRB = 1'b0; bus.i_BIT = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: good page
    arm();
    check("s1_busy_hunt", 16'(bus.o_BUSY), 16'h1);
    send_noise();
    send_body(8'hB1, 1'b0, 1'b0);
    check("s1_busy_fall", 16'(bus.o_BUSY), 16'h0);
    check("s1_last_byte", 16'(bus.o_BYTE), 16'h39);
    check("s1_crc_err",   16'(bus.o_CRC_ERR), 16'h0);
    check_drained("s1");

    // 2: corrupted CRC tail
    arm();
    send_noise();
    send_body(8'hB0, 1'b1, 1'b0);
    check("s2_crc_err_hold", 16'(bus.o_CRC_ERR), CRC_ON ? 16'h1 : 16'h0);
    check_drained("s2");

    // 3: strobe gaps and clock-enable hold
    arm();
    check("s3_err_cleared", 16'(bus.o_CRC_ERR), 16'h0);
    send_noise();
    send_body(8'hB1, 1'b0, 1'b1);
    check_drained("s3");

    // 4: only 15 sync bits must not lock
    arm();
    for (int i = 14; i >= 0; i--) send_bit(s[i]);
    check("s4_still_hunt", 16'(bus.o_BUSY), 16'h1);
    send_body(8'hB1, 1'b0, 1'b0);
    check_drained("s4");

    // 5: abort with arm after four data bytes
    arm();
    send_noise();
    for (int i = 15; i >= 0; i--) send_bit(s[i]);
    for (int k = 0; k < 4; k++) begin
      exp_byte_q.push_back(msg[k]);
      send_byte(msg[k]);
    end
    bus.i_ABORT = 1'b1; bus.i_ARM = 1'b1;
    tick();
    bus.i_ABORT = 1'b0; bus.i_ARM = 1'b0;
    check("s5_busy_after_abort", 16'(bus.o_BUSY), 16'h0);
    check("s5_byte_hold", 16'(bus.o_BYTE), 16'h34);
    for (int i = 15; i >= 0; i--) send_bit(s[i]);
    send_byte(8'h55);
    check("s5_idle_no_busy", 16'(bus.o_BUSY), 16'h0);
    check_drained("s5a");
    arm();
    send_noise();
    send_body(8'hB1, 1'b0, 1'b0);
    check_drained("s5b");

    // 6: async reset during the CRC tail
    arm();
    send_noise();
    for (int i = 15; i >= 0; i--) send_bit(s[i]);
    for (int k = 0; k < int'(PB); k++) begin
      exp_byte_q.push_back(msg[k]);
      send_byte(msg[k]);
    end
    if (!CRC_ON) exp_done_q.push_back(1'b0);
    send_byte(8'h29);
    check("s6_busy_before_rst", 16'(bus.o_BUSY), CRC_ON ? 16'h1 : 16'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    tick();
    rst_n = 1'b1;
    tick();
    send_noise();
    for (int i = 15; i >= 0; i--) send_bit(s[i]);
    send_byte(8'h31);
    repeat (3) tick();
    check("s6_idle_busy", 16'(bus.o_BUSY), 16'h0);
    check("s6_idle_byte", 16'(bus.o_BYTE), 16'h0);
    check_drained("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/k005297_page_deframer.md
Name: k005297_page_deframer

Overview:
- Receive-side stage that consumes the serial bit stream read from bubble memory.
- Hunts for a sync word, deserializes the following page into bytes, and appends a 2-byte CRC check.
- Hands bytes to the controller's buffer/DMA stage with a one-cycle valid strobe.
- Sits between the bubble detector input latch and the page buffer writer.

Parameters:
- SYNC_WORD, 16'hA5C3, sync pattern, compared MSB-first against the last 16 received bits.
- PAGE_BYTES, 64, data bytes per page, excluding the CRC (legal range 1..255).

Ports:
- i_CLK  in  1  system clock
- i_MRST_n  in  1  asynchronous active-low master reset
- i_CEN_n  in  1  clock enable, active-low; all state advances only when low
- i_ARM  in  1  start the sync hunt; sampled in IDLE or DONE
- i_ABORT  in  1  return to IDLE at the next enabled edge; overrides everything except reset
- i_BITSTRB  in  1  the current i_BIT is valid this enabled cycle
- i_BIT  in  1  serial data, MSB-first
- o_BYTE  out  8  assembled byte, held until the next byte
- o_BYTE_VLD  out  1  one enabled-cycle pulse per data byte (CRC bytes excluded)
- o_PAGE_DONE  out  1  one enabled-cycle pulse after the last CRC byte
- o_CRC_ERR  out  1  CRC result of the last page; valid from o_PAGE_DONE until the next ARM
- o_BUSY  out  1  high in HUNT, DATA and CRC

Behaviour:
- Reset: all outputs are 0, the state is IDLE, the shift register is 0, the counters are 0, and the CRC register is 16'hFFFF.
- State IDLE:
  - i_ARM moves to HUNT.
  - Entering HUNT clears the 16-bit shift register and clears o_CRC_ERR.
- State HUNT:
  - Each strobed bit shifts in: sr <= {sr[14:0], i_BIT}.
  - When the post-shift value equals SYNC_WORD, move to DATA with bit count 0, byte count 0, CRC register 16'hFFFF.
  - A match is only possible after at least 16 bits have been shifted since arming; a bit counter saturates at 16 to enforce this.
- State DATA:
  - Each strobed bit shifts into the byte register.
  - On the 8th bit, the byte is registered to o_BYTE in the same edge, with o_BYTE_VLD=1 for that enabled cycle.
  - The CRC register consumes the byte, the byte count increments, and the bit count wraps to 0.
  - When the byte count reaches PAGE_BYTES, move to CRC.
  - Total latency from the 8th bit strobe to o_BYTE_VLD is 1 enabled edge.
- State CRC:
  - Two more bytes are assembled and fed into the CRC without an o_BYTE_VLD pulse, and o_BYTE is not updated.
  - After the second byte, go to DONE.
  - Set o_PAGE_DONE=1 for one enabled cycle, and o_CRC_ERR = (CRC register != 16'h0000).
- State DONE: o_BUSY=0; i_ARM restarts HUNT; otherwise hold.
- CRC definition:
  - CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - It runs over the data bytes plus the received CRC bytes (high byte first), so the residue is 0 when the page is good.
  - The CRC may be computed a byte at a time combinationally or a bit at a time per strobe; either way the result at DONE is identical.
- i_CEN_n high: the whole block freezes, strobes are ignored, and any pulses in flight stretch until the next enabled edge.
- i_BITSTRB low in an enabled cycle: nothing shifts or counts; pulse outputs return to 0.
- Simultaneous i_ABORT and i_ARM: abort wins and the state goes to IDLE.
  - Abort clears o_BUSY and the counters, and suppresses o_PAGE_DONE.
  - o_BYTE and o_CRC_ERR hold.
- i_ARM while in HUNT, DATA or CRC is ignored.
- Asynchronous reset mid-page: outputs clear immediately, with no partial-byte or done pulse.
- Byte count width is 8 bits; PAGE_BYTES=255 must not overflow before the transition to CRC.

Optional Feature:
- Macro: K005297_DEFRAMER_CRC_EN.
- Defined: CRC logic is as above, and the page comprises PAGE_BYTES data bytes plus 2 CRC bytes.
- Undefined:
  - No CRC hardware and no CRC state; DATA moves straight to DONE after PAGE_BYTES bytes.
  - o_PAGE_DONE pulses on the edge after the last o_BYTE_VLD.
  - o_CRC_ERR is tied to 0.

Test Plan:
1. Reset and arm with PAGE_BYTES=9, CRC enabled. Send 5 noise bits 10110, sync A5C3, ASCII "123456789", then 8'h29, 8'hB1 -> nine o_BYTE_VLD pulses with 31..39 in order; o_PAGE_DONE once; o_CRC_ERR=0; o_BUSY then falls.
2. Same stream with the final CRC byte changed to 8'hB0 -> all nine bytes still delivered; o_PAGE_DONE pulses with o_CRC_ERR=1.
3. Sync pattern split by i_BITSTRB gaps and held i_CEN_n=1 for 3 cycles mid-byte -> byte values are identical to scenario 1, and no extra or missing pulses occur.
4. Only 15 bits sent after arming whose last 15 match the low bits of the sync -> no lock; after the 16th correct bit, DATA is entered exactly once.
5. i_ABORT asserted after 4 data bytes, together with i_ARM -> IDLE, o_BUSY=0, no o_PAGE_DONE, o_BYTE holds 8'h34; a re-arm then works normally.
6. Assert i_MRST_n low during the CRC state -> all outputs are 0 asynchronously; after release the state is IDLE and i_BIT activity produces no output until i_ARM.
